// File: rtl/approx_mac_accumulator.sv
// approx_mac_accumulator: sums a stream of signed products into one result per group.
// Optional ACC_SAT_EN macro enables saturating addition and the sticky acc_sat flag.
module approx_mac_accumulator #(
   parameter int PROD_W  = 32,
   parameter int ACC_W   = 40,
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod_data,
   input  logic              prod_last,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_data,
   output logic [CNT_W-1:0]  acc_count,
   output logic              acc_len_err,
   output logic              acc_sat
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   state_t           state;
   state_t           state_nx;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc;
   logic             err;
   logic             err_nx;
   logic             sat;
   logic             sat_nx;
   logic             accept;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] sum;
   logic             sat_add;

   assign prod_ext   = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
   assign prod_ready = rst_n && (state != HOLD);
   assign accept     = prod_valid && prod_ready;
   assign cnt_inc    = cnt + ONE_CNT;

`ifdef ACC_SAT_EN
   logic [ACC_W-1:0] raw;
   logic             ovf;

   assign raw = acc + prod_ext;
   assign ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (raw[ACC_W-1] != acc[ACC_W-1]);

   // clamp toward the sign of the operands on signed overflow
   always_comb begin
      sum     = raw;
      sat_add = ovf;
      if (ovf) begin
         if (acc[ACC_W-1])
            sum = {1'b1, {(ACC_W-1){1'b0}}};
         else
            sum = {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign sum     = acc + prod_ext;
   assign sat_add = 1'b0;
`endif

   // next-state and next-value logic for the group FSM
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      cnt_nx   = cnt;
      err_nx   = err;
      sat_nx   = sat;
      unique case (state)
         IDLE: begin
            if (accept) begin
               acc_nx = prod_ext;
               cnt_nx = ONE_CNT;
               err_nx = 1'b0;
               sat_nx = 1'b0;
               if (prod_last || (MAX_LEN == 1)) begin
                  state_nx = HOLD;
                  err_nx   = !prod_last;
               end else begin
                  state_nx = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_nx = sum;
               cnt_nx = cnt_inc;
               sat_nx = sat | sat_add;
               if (prod_last) begin
                  state_nx = HOLD;
               end else if (cnt_inc == MAX_CNT) begin
                  state_nx = HOLD;
                  err_nx   = 1'b1;
               end
            end
         end
         HOLD: begin
            if (acc_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // state and result registers; reset discards any partial group
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         err   <= 1'b0;
         sat   <= 1'b0;
      end else begin
         state <= state_nx;
         acc   <= acc_nx;
         cnt   <= cnt_nx;
         err   <= err_nx;
         sat   <= sat_nx;
      end
   end

   assign acc_valid   = (state == HOLD);
   assign acc_data    = acc;
   assign acc_count   = cnt;
   assign acc_len_err = err;
   assign acc_sat     = sat;

endmodule

// File: tb/tb_approx_mac_accumulator.sv
// tb_approx_mac_accumulator: directed and random groups on three configurations
// (default, MAX_LEN=4, ACC_W=33) checked against an arithmetic group model.
module tb_approx_mac_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pv;
   logic        pl;
   logic        ar;
   logic [31:0] pd;
   int          sel;

   logic        rdy0, rdy1, rdy2;
   logic        v0, v1, v2;
   logic [39:0] d0, d1;
   logic [32:0] d2;
   logic [8:0]  c0, c2;
   logic [2:0]  c1;
   logic        e0, e1, e2;
   logic        s0, s1, s2;

   logic               cur_ready;
   logic               cur_valid;
   logic signed [39:0] cur_data;
   logic [8:0]         cur_count;
   logic               cur_err;
   logic               cur_sat;

   int n_cmp = 0;
   int n_bad = 0;

   int accw [3] = '{40, 40, 33};
   int maxl [3] = '{256, 4, 256};

   longint mraw [3];
   longint mcl  [3];
   int     mlen [3];
   bit     msat [3];

   longint ex_data;
   longint ex_count;
   bit     ex_err;
   bit     ex_sat;

   always #5 clk = ~clk;

   approx_mac_accumulator u0 (
      .clk(clk), .rst_n(rst_n),
      .prod_valid(pv && sel == 0), .prod_ready(rdy0),
      .prod_data(pd), .prod_last(pl),
      .acc_valid(v0), .acc_ready(ar),
      .acc_data(d0), .acc_count(c0),
      .acc_len_err(e0), .acc_sat(s0)
   );

   approx_mac_accumulator #(
      .MAX_LEN(4), .CNT_W(3)
   ) u1 (
      .clk(clk), .rst_n(rst_n),
      .prod_valid(pv && sel == 1), .prod_ready(rdy1),
      .prod_data(pd), .prod_last(pl),
      .acc_valid(v1), .acc_ready(ar),
      .acc_data(d1), .acc_count(c1),
      .acc_len_err(e1), .acc_sat(s1)
   );

   approx_mac_accumulator #(
      .ACC_W(33)
   ) u2 (
      .clk(clk), .rst_n(rst_n),
      .prod_valid(pv && sel == 2), .prod_ready(rdy2),
      .prod_data(pd), .prod_last(pl),
      .acc_valid(v2), .acc_ready(ar),
      .acc_data(d2), .acc_count(c2),
      .acc_len_err(e2), .acc_sat(s2)
   );

   always_comb begin
      cur_ready = rdy0;
      cur_valid = v0;
      cur_data  = d0;
      cur_count = c0;
      cur_err   = e0;
      cur_sat   = s0;
      case (sel)
         1: begin
            cur_ready = rdy1;
            cur_valid = v1;
            cur_data  = d1;
            cur_count = {6'd0, c1};
            cur_err   = e1;
            cur_sat   = s1;
         end
         2: begin
            cur_ready = rdy2;
            cur_valid = v2;
            cur_data  = {{7{d2[32]}}, d2};
            cur_count = c2;
            cur_err   = e2;
            cur_sat   = s2;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag,
                      input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrapv(input longint v, input int w);
      longint m;
      longint r;
      m = longint'(1) <<< w;
      r = v & (m - 1);
      if (r >= (m >>> 1))
         r = r - m;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mlen[i] = 0;
         mraw[i] = 0;
         mcl[i]  = 0;
         msat[i] = 1'b0;
      end
   endtask

   task automatic chk_result(input string tag);
      chk({tag, "_valid"}, cur_valid, 1);
      chk({tag, "_data"},  cur_data,  ex_data);
      chk({tag, "_count"}, cur_count, ex_count);
      chk({tag, "_err"},   cur_err,   ex_err);
      chk({tag, "_sat"},   cur_sat,   ex_sat);
   endtask

   // drive one product to DUT k at a negedge; returns whether the group closed
   task automatic send(input int k, input logic [31:0] d,
                       input bit l, output bit closed);
      int     t;
      longint p;
      longint mx;
      longint mn;
      sel = k;
      pv  = 1'b1;
      pd  = d;
      pl  = l;
      t   = 0;
      #1;
      while (!cur_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!cur_ready) begin
         n_cmp++;
         n_bad++;
         $error("FAIL ready_timeout: observed 0 expected 1");
      end
      @(posedge clk);
      #1;
      pv = 1'b0;
      p  = longint'($signed(d));
      mx = (longint'(1) <<< (accw[k] - 1)) - 1;
      mn = -(longint'(1) <<< (accw[k] - 1));
      if (mlen[k] == 0) begin
         mraw[k] = p;
         mcl[k]  = p;
         msat[k] = 1'b0;
      end else begin
         mraw[k] = mraw[k] + p;
         mcl[k]  = mcl[k] + p;
         if (mcl[k] > mx) begin
            mcl[k]  = mx;
            msat[k] = 1'b1;
         end else if (mcl[k] < mn) begin
            mcl[k]  = mn;
            msat[k] = 1'b1;
         end
      end
      mlen[k]++;
      closed = l || (mlen[k] == maxl[k]);
      @(negedge clk);
      if (closed) begin
`ifdef ACC_SAT_EN
         ex_data = mcl[k];
         ex_sat  = msat[k];
`else
         ex_data = wrapv(mraw[k], accw[k]);
         ex_sat  = 1'b0;
`endif
         ex_count = mlen[k];
         ex_err   = !l;
         mlen[k]  = 0;
         chk_result("result");
      end else begin
         chk("mid_valid", cur_valid, 0);
      end
   endtask

   // result held under backpressure for n cycles
   task automatic hold(input int n);
      for (int i = 0; i < n; i++) begin
         chk("hold_valid", cur_valid, 1);
         chk("hold_ready", cur_ready, 0);
         chk("hold_data",  cur_data,  ex_data);
         chk("hold_count", cur_count, ex_count);
         @(negedge clk);
      end
   endtask

   task automatic take();
      ar = 1'b1;
      @(posedge clk);
      #1;
      ar = 1'b0;
      @(negedge clk);
      chk("take_valid", cur_valid, 0);
      chk("take_ready", cur_ready, 1);
      chk("take_data",  cur_data,  ex_data);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, rdy0, 0);
      chk({tag, "_valid"}, v0, 0);
      chk({tag, "_data"},  d0, 0);
      chk({tag, "_count"}, c0, 0);
      chk({tag, "_err"},   e0, 0);
      chk({tag, "_sat"},   s0, 0);
      chk({tag, "_data2"}, d2, 0);
   endtask

   initial begin
      bit cl;
      int k;
      logic [31:0] d;

      rst_n = 1'b0;
      pv    = 1'b0;
      pl    = 1'b0;
      ar    = 1'b0;
      pd    = '0;
      sel   = 0;
      model_reset();
      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(0, 32'd11, 1'b0, cl);
      send(0, 32'd22, 1'b0, cl);
      send(0, 32'd33, 1'b0, cl);
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);

      send(0, 32'd100, 1'b0, cl);
      send(0, -32'sd40, 1'b0, cl);
      send(0, 32'd7, 1'b1, cl);
      chk("basic_data", cur_data, 67);
      hold(1);
      take();

      send(0, 32'h7FFF_FFFF, 1'b0, cl);
      send(0, 32'd1, 1'b1, cl);
      chk("bp_data", cur_data, 40'sh00_8000_0000);
      pv = 1'b1;
      pd = 32'd999;
      pl = 1'b1;
      hold(5);
      pv = 1'b0;
      take();

      sel = 1;
      send(1, 32'd1, 1'b0, cl);
      send(1, 32'd2, 1'b0, cl);
      send(1, 32'd3, 1'b0, cl);
      send(1, 32'd4, 1'b0, cl);
      chk("cap_data", cur_data, 10);
      chk("cap_err", cur_err, 1);
      take();
      send(1, 32'd5, 1'b1, cl);
      chk("cap_next", cur_data, 5);
      take();
      for (int i = 0; i < 4; i++)
         send(1, 32'd2, i == 3, cl);
      chk("lastcap_err", cur_err, 0);
      take();

      for (int i = 0; i < 3; i++)
         send(2, 32'h7FFF_FFFF, i == 2, cl);
`ifdef ACC_SAT_EN
      chk("ovf_data", cur_data, 40'sh00_FFFF_FFFF);
      chk("ovf_sat", cur_sat, 1);
`else
      chk("ovf_data", cur_data, -40'sh00_8000_0003);
      chk("ovf_sat", cur_sat, 0);
`endif
      take();

      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(0, 2);
         if (mlen[0] > 0) k = 0;
         if (mlen[1] > 0) k = 1;
         if (mlen[2] > 0) k = 2;
         if (k == 2)
            d = $urandom_range(0, 1) ? (32'h7FFF_0000 | $urandom_range(0, 65535))
                                     : (32'h8000_0000 | $urandom_range(0, 65535));
         else
            d = $urandom;
         send(k, d, $urandom_range(0, 3) == 0, cl);
         if (cl) begin
            hold($urandom_range(0, 3));
            take();
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (mlen[i] > 0) begin
            send(i, 32'd3, 1'b1, cl);
            take();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/approx_mac_accumulator.md
Name: approx_mac_accumulator

Overview:
- Downstream consumer of the 16x16 signed approximate multiplier in the PE datapath.
- Takes a stream of 32-bit signed products and accumulates them into a wide signed sum, one dot-product group per frame; a group ends when the producer marks its last product.
- Presents the finished sum to the PE output/writeback stage over a valid/ready handshake.
- Provides the accumulate stage that turns per-element approximate products into dot-product results.

Parameters:
- PROD_W, 32, width of signed input product.
- ACC_W, 40, width of signed accumulator/result (must be >= PROD_W + 1).
- MAX_LEN, 256, maximum products per group; forced group close at this count.
- CNT_W, 9, width of element counter (must hold MAX_LEN).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prod_valid  in  1  product present.
- prod_ready  out  1  block accepts product this cycle.
- prod_data  in  PROD_W  signed product.
- prod_last  in  1  product is final element of group.
- acc_valid  out  1  result held and valid.
- acc_ready  in  1  downstream takes result.
- acc_data  out  ACC_W  signed accumulated sum.
- acc_count  out  CNT_W  number of products in group.
- acc_len_err  out  1  group closed by MAX_LEN, not by prod_last.
- acc_sat  out  1  saturation occurred in group (0 when ACC_SAT_EN off).

Behaviour:
- Reset (rst_n low, async): state=IDLE; acc_data=0, acc_count=0, acc_valid=0, acc_len_err=0, acc_sat=0; prod_ready=0 while in reset. Reset mid-group discards the partial sum.
- Product accepted when prod_valid && prod_ready; prod_data is sign-extended to ACC_W.
- prod_ready=1 in IDLE and ACCUM; 0 in HOLD.
- acc_valid=1 only in HOLD; acc_data/count/flags stable while acc_valid && !acc_ready.
- IDLE:
  - On accept: acc=sext(prod), count=1, flags cleared.
  - If prod_last, or MAX_LEN==1, go to HOLD; else go to ACCUM.
- ACCUM:
  - On accept: acc=acc+sext(prod), count+=1.
  - If prod_last, go to HOLD.
  - Else if the new count==MAX_LEN, go to HOLD with acc_len_err=1.
  - No accept: hold state and values.
- HOLD: on acc_ready go to IDLE; outputs keep their last values, acc_valid drops next cycle.
- Latency and throughput:
  - Result visible one cycle after the accepting edge of the last product.
  - One bubble cycle per group (the HOLD handshake cycle) minimum.
- prod_last together with reaching MAX_LEN: acc_len_err=0 (last takes precedence).
- prod_valid while in HOLD: not accepted; producer must hold data.
- Arithmetic: two's complement, ACC_W-bit addition. Without ACC_SAT_EN the sum wraps modulo 2^ACC_W.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - Each addition is checked for signed overflow.
  - On positive overflow acc clamps to 2^(ACC_W-1)-1; on negative overflow to -2^(ACC_W-1).
  - acc_sat is set sticky for the group and cleared on the first accept in IDLE.
- Undefined: wrapping addition; acc_sat tied to 0; no overflow logic synthesised.

Test Plan:
- Reset mid-group: 3 products then rst_n low for 1 cycle -> all outputs 0, state IDLE; next group starts from 0 and no stale sum appears.
- Basic group: products 100, -40, 7 (last on 7), acc_ready=1 -> acc_valid one cycle after last, acc_data=67, acc_count=3, acc_len_err=0; prod_ready low during HOLD.
- Backpressure: group {0x7FFFFFFF, 1 last} with acc_ready=0 for 5 cycles -> acc_data=0x0080000000 held stable, prod_ready=0 throughout; release -> IDLE next cycle.
- Length cap: MAX_LEN=4, stream 1,2,3,4,5 with no last -> first result 10, count=4, acc_len_err=1; then 5 starts a new group; 5 with last -> result 5, len_err=0.
- Last at cap: MAX_LEN=4, four products of 2 with last on the fourth -> result 8, count=4, acc_len_err=0.
- Overflow with ACC_W=33: two products of 0x7FFFFFFF then 0x7FFFFFFF last -> with ACC_SAT_EN result 0x0FFFFFFFF, acc_sat=1; without it the result wraps to -0x080000003 (0x17FFFFFFD), acc_sat=0.
